// File: rtl/laconic_pe_acc.sv
// laconic_pe_acc: Laconic-style processing-element accumulator.
//
// Each accepted beat carries N lanes of signed exponent-term pairs (t0, t1, s0, s1).
// An applied lane adds +/-1 to bin e = t0 + t1. Bins are summed over a pass of beats,
// and the pass result is sum(bin[b] * 2^b).
//
// Pipeline:
//   S1  - per-beat bin counts, registered on the accept edge
//   S2  - bin accumulators; a last beat snapshots them into fin and clears them
//   S3  - weighted sum of fin, split into half sums and then a final add
//
// Ports:
//   clk, rst               - clock and asynchronous active-high reset
//   in_valid/in_ready      - beat handshake; in_last closes the pass
//   in_applied, t0, t1,    - per-lane term-present flag, exponent terms and sign bits
//   s0, s1
//   out_valid/out_ready    - result handshake
//   out_value              - signed pass result, OW bits
//   out_ovf                - pass exceeded MAXT beats
module laconic_pe_acc #(
  parameter int unsigned N    = 16,
  parameter int unsigned EW   = 3,
  parameter int unsigned MAXT = 8,
  localparam int unsigned NB  = 1 << (EW + 1),
  localparam int unsigned HW  = $clog2(N * MAXT + 1) + 1,
  localparam int unsigned OW  = HW + NB - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [N-1:0]         in_applied,
  input  logic [N*EW-1:0]      t0,
  input  logic [N*EW-1:0]      t1,
  input  logic [N-1:0]         s0,
  input  logic [N-1:0]         s1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_value,
  output logic                 out_ovf
);

  localparam int unsigned CW = $clog2(MAXT + 2);
  localparam logic [CW-1:0] MaxtC = CW'(MAXT);

  logic stall;
  logic accept;

  // Per-beat bin counts (combinational)
  logic [EW:0]          lane_e;
  logic signed [HW-1:0] beat_cnt [NB];

  // Beat counter
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // S1
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic                 s1_ovf_q, s1_ovf_d;
  logic signed [HW-1:0] s1_cnt_q [NB];
  logic signed [HW-1:0] s1_cnt_d [NB];

  // S2. Bins are kept OW wide (not just HW) so a pass that overruns MAXT still
  // produces a result that is exact modulo 2^OW.
  logic signed [OW-1:0] acc_q [NB];
  logic signed [OW-1:0] acc_d [NB];
  logic signed [OW-1:0] fin_q [NB];
  logic signed [OW-1:0] fin_d [NB];
  logic                 fin_valid_q, fin_valid_d;
  logic                 fin_ovf_q, fin_ovf_d;

  // S3
  logic signed [OW-1:0] lo_sum, hi_sum;
  logic signed [OW-1:0] ps_lo_q, ps_lo_d, ps_hi_q, ps_hi_d;
  logic                 ps_valid_q, ps_valid_d;
  logic                 ps_ovf_q, ps_ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_value_q, out_value_d;
  logic                 out_ovf_q, out_ovf_d;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_ovf   = out_ovf_q;

  // Saturates at MAXT+1 so out_ovf stays set for the rest of a long pass.
  assign cnt_inc = (cnt_q > MaxtC) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    lane_e = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      beat_cnt[b] = '0;
    end
    for (int unsigned i = 0; i < N; i++) begin
      lane_e = {1'b0, t0[EW*i +: EW]} + {1'b0, t1[EW*i +: EW]};
      if (in_applied[i]) begin
        if (s0[i] ^ s1[i]) begin
          beat_cnt[lane_e] = beat_cnt[lane_e] - HW'(1);
        end else begin
          beat_cnt[lane_e] = beat_cnt[lane_e] + HW'(1);
        end
      end
    end
  end

  // Weighted sum of the snapshot, split in halves to shorten the adder tree.
  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b < NB / 2) begin
        lo_sum = lo_sum + (fin_q[b] << b);
      end else begin
        hi_sum = hi_sum + (fin_q[b] << b);
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_ovf_d    = s1_ovf_q;
    s1_cnt_d    = s1_cnt_q;
    acc_d       = acc_q;
    fin_d       = fin_q;
    fin_valid_d = fin_valid_q;
    fin_ovf_d   = fin_ovf_q;
    ps_lo_d     = ps_lo_q;
    ps_hi_d     = ps_hi_q;
    ps_valid_d  = ps_valid_q;
    ps_ovf_d    = ps_ovf_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_ovf_d   = out_ovf_q;

    // A stall freezes every stage; nothing is accepted while it lasts.
    if (!stall) begin
      // S1
      s1_valid_d = accept;
      s1_last_d  = accept & in_last;
      if (accept) begin
        s1_cnt_d = beat_cnt;
        s1_ovf_d = cnt_inc > MaxtC;
        cnt_d    = in_last ? '0 : cnt_inc;
      end

      // S2
      fin_valid_d = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (s1_last_q) begin
            fin_d[b] = acc_q[b] + {{(OW-HW){s1_cnt_q[b][HW-1]}}, s1_cnt_q[b]};
            acc_d[b] = '0;
          end else begin
            acc_d[b] = acc_q[b] + {{(OW-HW){s1_cnt_q[b][HW-1]}}, s1_cnt_q[b]};
          end
        end
        if (s1_last_q) begin
          fin_ovf_d = s1_ovf_q;
        end
      end

      // S3: half sums
      ps_valid_d = fin_valid_q;
      if (fin_valid_q) begin
        ps_lo_d  = lo_sum;
        ps_hi_d  = hi_sum;
        ps_ovf_d = fin_ovf_q;
      end

      // S3: result register. Without a stall out_valid is either consumed or low,
      // so it simply follows the incoming load.
      out_valid_d = ps_valid_q;
      if (ps_valid_q) begin
        out_value_d = ps_lo_q + ps_hi_q;
        out_ovf_d   = ps_ovf_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_ovf_q    <= 1'b0;
      fin_valid_q <= 1'b0;
      fin_ovf_q   <= 1'b0;
      ps_lo_q     <= '0;
      ps_hi_q     <= '0;
      ps_valid_q  <= 1'b0;
      ps_ovf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ovf_q   <= 1'b0;
      for (int unsigned b = 0; b < NB; b++) begin
        s1_cnt_q[b] <= '0;
        acc_q[b]    <= '0;
        fin_q[b]    <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_ovf_q    <= s1_ovf_d;
      fin_valid_q <= fin_valid_d;
      fin_ovf_q   <= fin_ovf_d;
      ps_lo_q     <= ps_lo_d;
      ps_hi_q     <= ps_hi_d;
      ps_valid_q  <= ps_valid_d;
      ps_ovf_q    <= ps_ovf_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_ovf_q   <= out_ovf_d;
      for (int unsigned b = 0; b < NB; b++) begin
        s1_cnt_q[b] <= s1_cnt_d[b];
        acc_q[b]    <= acc_d[b];
        fin_q[b]    <= fin_d[b];
      end
    end
  end

endmodule
